mem_stage_hs: RTL and testbench
===============================

// Module: mem_stage_hs
// PURPOSE
//  Parametrised data-memory pipeline stage with a req/ack handshake to a variable-latency data memory.
//  Sits between EX/MEM and MEM/WB. Executes byte/half/word loads and stores on big-endian lanes
//  (byte 0 = [DATA_W-1 -: 8]). Provides WB->MEM store-data bypass, stalls upstream while a
//  memory access is outstanding, and flags misalignment and ack timeout.
// PARAMETERS
//  DATA_W     32   data/address width; multiple of 16, >= 32; BE_W = DATA_W/8
//  REG_AW     5    register-index width
//  TIMEOUT    255  cycles in BUSY without dm_ack before the bus error; 1..2^16-1
// PORTS
//  CLK           in   1       clock, rising edge
//  RESET         in   1       asynchronous, active-high
//  in_valid      in   1       EX/MEM holds a valid op; held stable while stall=1
//  in_op         in   4       op code (mem_pkg: OP_NONE, LW, LH, LHU, LB, LBU, SW, SH, SB)
//  in_addr       in   DATA_W  effective address (ALU result)
//  in_sdata      in   DATA_W  store data from the register file
//  in_src_reg    in   REG_AW  source register of the store data
//  in_dst_reg    in   REG_AW  destination register
//  in_wb_en      in   1       op writes back
//  wb_valid      in   1       WB stage is writing
//  wb_reg        in   REG_AW  WB destination register
//  wb_data       in   DATA_W  WB write data (bypass source)
//  dm_req        out  1       memory request; held until dm_ack
//  dm_we         out  1       1 = store
//  dm_be         out  BE_W    byte enables, bit BE_W-1 = byte 0
//  dm_addr       out  DATA_W  word address (low log2(BE_W) bits forced to 0)
//  dm_wdata      out  DATA_W  store data replicated into the lanes
//  dm_ack        in   1       one-cycle completion strobe; dm_rdata valid in the same cycle
//  dm_rdata      in   DATA_W  read word
//  stall         out  1       upstream must hold its inputs
//  out_valid     out  1       MEM/WB register valid
//  out_wb_en     out  1       MEM/WB write enable
//  out_reg       out  REG_AW  MEM/WB destination register
//  out_data      out  DATA_W  aligned load data or ALU result
//  misalign      out  1       one-cycle pulse, aligned with out_valid
//  bus_err       out  1       one-cycle pulse on timeout
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, timeout counter 0. dm_req drops immediately when RESET asserts,
//   including mid-transaction; the outstanding access is abandoned.
//  FSM IDLE / BUSY. stall = (state == BUSY).
//  IDLE, in_valid, op is non-memory: next edge out_valid=1, out_data=in_addr, out_wb_en=in_wb_en
//   (1-cycle latency).
//  IDLE, in_valid, memory op, aligned: capture op/addr/regs -> BUSY. dm_req=1 from the next cycle.
//   Store data is captured at accept: bypass = wb_valid && wb_reg==in_src_reg && wb_reg!=0.
//  Misaligned (LW/SW: addr[1:0]!=0; LH/LHU/SH: addr[0]!=0): no dm_req. Next edge out_valid=1,
//   out_wb_en=0, misalign=1.
//  BUSY: dm_req, dm_we, dm_be, dm_addr and dm_wdata are stable. On dm_ack: -> IDLE; on that edge
//   out_valid=1, out_data=align(dm_rdata), out_wb_en = in_wb_en and the op is a load.
//  Stores: out_valid=1 and out_wb_en=0 on ack.
//  Timeout counter counts BUSY cycles. At TIMEOUT without ack: -> IDLE, bus_err=1,
//   out_valid=1, out_wb_en=0. A dm_ack arriving in the timeout cycle wins.
//  out_valid is 0 in every cycle not listed above.
//  Load alignment: LB/LBU select the byte at addr offset; LH/LHU select the half; sign- or
//   zero-extend to DATA_W. LW passes the word.
//  Store lanes: SB sets be=one-hot at the offset, wdata = byte replicated to all lanes. SH sets 2
//   bits, half replicated. SW sets all ones.
//  dm_ack in IDLE is ignored.
// STRUCTURE
//  mem_pkg: op encodings, op class functions (is_load, is_store, size), FSM state typedef.
//  Sub-module mem_load_align (combinational: rdata, offset, op -> aligned data). Everything else
//   lives in this module: FSM, timeout counter, bypass mux, lane/byte-enable generation,
//   MEM/WB register.
// TESTING
//  ALU op: in_addr=0x1234, in_wb_en=1, dst=5 -> next cycle out_valid=1, out_data=0x1234,
//   out_reg=5, stall=0.
//  LB at addr 0x101, ack after 3 cycles with rdata 0x11F2_3344 -> stall 3 cycles,
//   out_data=0xFFFF_FFF2.
//  Same access as LBU -> out_data=0x0000_00F2.
//  SH at 0x202, in_sdata=0xAAAA_BEEF, wb_valid=1, wb_reg=src=7, wb_data=0x0000_1234 ->
//   dm_be=4'b0011, dm_wdata=0x1234_1234, dm_addr=0x200, out_wb_en=0.
//  LW at 0x103 -> no dm_req, misalign=1, out_valid=1, out_wb_en=0. LW with no ack and TIMEOUT=8
//   -> bus_err after 8 BUSY cycles, FSM returns to IDLE.
//  RESET asserted in the second BUSY cycle -> dm_req=0 immediately, all outputs 0. A dm_ack
//   arriving after release is ignored.

Source files
------------

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - op encodings, op-class helpers and FSM state type for the memory stage
package mem_pkg;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_LW   = 4'd1,
        OP_LH   = 4'd2,
        OP_LHU  = 4'd3,
        OP_LB   = 4'd4,
        OP_LBU  = 4'd5,
        OP_SW   = 4'd6,
        OP_SH   = 4'd7,
        OP_SB   = 4'd8
    } op_e;

    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_e;

    typedef enum logic {ST_IDLE, ST_BUSY} state_e;

    function automatic logic is_load(input logic [3:0] op);
        return (op == OP_LW) || (op == OP_LH) || (op == OP_LHU) ||
               (op == OP_LB) || (op == OP_LBU);
    endfunction

    function automatic logic is_store(input logic [3:0] op);
        return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
    endfunction

    function automatic logic is_signed_load(input logic [3:0] op);
        return (op == OP_LH) || (op == OP_LB);
    endfunction

    function automatic size_e op_size(input logic [3:0] op);
        size_e sz;
        case (op)
            OP_LB, OP_LBU, OP_SB: sz = SZ_B;
            OP_LH, OP_LHU, OP_SH: sz = SZ_H;
            default:              sz = SZ_W;
        endcase
        return sz;
    endfunction

    // Alignment is judged on the two low address bits only.
    function automatic logic is_misaligned(input logic [3:0] op, input logic [1:0] lo);
        logic mis;
        mis = 1'b0;
        if (is_load(op) || is_store(op)) begin
            case (op_size(op))
                SZ_W:    mis = (lo != 2'b00);
                SZ_H:    mis = lo[0];
                default: mis = 1'b0;
            endcase
        end
        return mis;
    endfunction

endpackage

// File: rtl/mem_load_align.sv
// rtl/mem_load_align.sv - selects and extends the addressed byte/half of a big-endian read word
module mem_load_align
    import mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OFF_W  = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [OFF_W-1:0]  offset,
    input  logic [3:0]        op,
    output logic [DATA_W-1:0] data
);

    logic [DATA_W-1:0] shifted;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;

    // Shifting left by the byte offset brings the addressed lane to the top (byte 0 position).
    always_comb begin
        shifted  = rdata << {offset, 3'b000};
        byte_sel = shifted[DATA_W-1 -: 8];
        half_sel = shifted[DATA_W-1 -: 16];
        case (op_size(op))
            SZ_B:    data = is_signed_load(op) ? {{(DATA_W-8){byte_sel[7]}}, byte_sel}
                                               : {{(DATA_W-8){1'b0}}, byte_sel};
            SZ_H:    data = is_signed_load(op) ? {{(DATA_W-16){half_sel[15]}}, half_sel}
                                               : {{(DATA_W-16){1'b0}}, half_sel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_hs.sv
// rtl/mem_stage_hs.sv - data-memory pipeline stage with req/ack handshake, bypass and timeout
module mem_stage_hs
    import mem_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int REG_AW  = 5,
    parameter int TIMEOUT = 255
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   in_valid,
    input  logic [3:0]             in_op,
    input  logic [DATA_W-1:0]      in_addr,
    input  logic [DATA_W-1:0]      in_sdata,
    input  logic [REG_AW-1:0]      in_src_reg,
    input  logic [REG_AW-1:0]      in_dst_reg,
    input  logic                   in_wb_en,
    input  logic                   wb_valid,
    input  logic [REG_AW-1:0]      wb_reg,
    input  logic [DATA_W-1:0]      wb_data,
    output logic                   dm_req,
    output logic                   dm_we,
    output logic [DATA_W/8-1:0]    dm_be,
    output logic [DATA_W-1:0]      dm_addr,
    output logic [DATA_W-1:0]      dm_wdata,
    input  logic                   dm_ack,
    input  logic [DATA_W-1:0]      dm_rdata,
    output logic                   stall,
    output logic                   out_valid,
    output logic                   out_wb_en,
    output logic [REG_AW-1:0]      out_reg,
    output logic [DATA_W-1:0]      out_data,
    output logic                   misalign,
    output logic                   bus_err
);

    localparam int BE_W  = DATA_W / 8;
    localparam int OFF_W = $clog2(BE_W);
    localparam logic [15:0]     TO_LAST = 16'(TIMEOUT - 1);
    localparam logic [BE_W-1:0] BE_ONE  = BE_W'(1);
    localparam logic [BE_W-1:0] BE_TWO  = BE_W'(3);

    state_e              state_q, state_d;
    logic [15:0]         cnt_q, cnt_d;
    logic [3:0]          op_q, op_d;
    logic [OFF_W-1:0]    off_q, off_d;
    logic [REG_AW-1:0]   dst_q, dst_d;
    logic                wb_en_q, wb_en_d;
    logic                dm_we_q, dm_we_d;
    logic [BE_W-1:0]     dm_be_q, dm_be_d;
    logic [DATA_W-1:0]   dm_addr_q, dm_addr_d;
    logic [DATA_W-1:0]   dm_wdata_q, dm_wdata_d;
    logic                out_valid_q, out_valid_d;
    logic                out_wb_en_q, out_wb_en_d;
    logic [REG_AW-1:0]   out_reg_q, out_reg_d;
    logic [DATA_W-1:0]   out_data_q, out_data_d;
    logic                misalign_q, misalign_d;
    logic                bus_err_q, bus_err_d;

    logic [OFF_W-1:0]    in_off;
    logic                in_mem, in_mis, accept, timeout, bypass;
    logic [DATA_W-1:0]   sdata, lane_wdata, load_data;
    logic [BE_W-1:0]     lane_be;

    assign in_off  = in_addr[OFF_W-1:0];
    assign in_mem  = is_load(in_op) || is_store(in_op);
    assign in_mis  = is_misaligned(in_op, in_addr[1:0]);
    assign accept  = (state_q == ST_IDLE) && in_valid && in_mem && !in_mis;
    // An ack in the final counted cycle takes priority over the timeout.
    assign timeout = (state_q == ST_BUSY) && !dm_ack && (cnt_q == TO_LAST);

    mem_load_align #(
        .DATA_W (DATA_W),
        .OFF_W  (OFF_W)
    ) u_align (
        .rdata  (dm_rdata),
        .offset (off_q),
        .op     (op_q),
        .data   (load_data)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_BUSY;
            ST_BUSY: if (dm_ack || timeout) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Request is a pure decode of the state flop so reset withdraws it without waiting for a clock.
    always_comb begin
        stall  = 1'b0;
        dm_req = 1'b0;
        if (state_q == ST_BUSY) begin
            stall  = 1'b1;
            dm_req = 1'b1;
        end
    end

    always_comb begin
        bypass = wb_valid && (wb_reg == in_src_reg) && (wb_reg != '0);
        sdata  = bypass ? wb_data : in_sdata;
        case (op_size(in_op))
            SZ_B: begin
                lane_wdata = {BE_W{sdata[7:0]}};
                lane_be    = BE_ONE << (OFF_W'(BE_W - 1) - in_off);
            end
            SZ_H: begin
                lane_wdata = {(BE_W/2){sdata[15:0]}};
                lane_be    = BE_TWO << (OFF_W'(BE_W - 2) - in_off);
            end
            default: begin
                lane_wdata = sdata;
                lane_be    = '1;
            end
        endcase
    end

    always_comb begin
        op_d       = op_q;
        off_d      = off_q;
        dst_d      = dst_q;
        wb_en_d    = wb_en_q;
        dm_we_d    = dm_we_q;
        dm_be_d    = dm_be_q;
        dm_addr_d  = dm_addr_q;
        dm_wdata_d = dm_wdata_q;
        cnt_d      = ((state_q == ST_BUSY) && (state_d == ST_BUSY)) ? cnt_q + 16'd1 : 16'd0;
        if (accept) begin
            op_d       = in_op;
            off_d      = in_off;
            dst_d      = in_dst_reg;
            wb_en_d    = in_wb_en;
            dm_we_d    = is_store(in_op);
            dm_be_d    = lane_be;
            dm_addr_d  = {in_addr[DATA_W-1:OFF_W], {OFF_W{1'b0}}};
            dm_wdata_d = lane_wdata;
        end
    end

    always_comb begin
        out_valid_d = 1'b0;
        out_wb_en_d = 1'b0;
        misalign_d  = 1'b0;
        bus_err_d   = 1'b0;
        out_reg_d   = out_reg_q;
        out_data_d  = out_data_q;
        if ((state_q == ST_IDLE) && in_valid && !accept) begin
            out_valid_d = 1'b1;
            out_reg_d   = in_dst_reg;
            out_data_d  = in_addr;
            if (in_mem) begin
                misalign_d = 1'b1;
            end else begin
                out_wb_en_d = in_wb_en;
            end
        end else if (state_q == ST_BUSY) begin
            if (dm_ack) begin
                out_valid_d = 1'b1;
                out_reg_d   = dst_q;
                out_data_d  = load_data;
                out_wb_en_d = wb_en_q && is_load(op_q);
            end else if (timeout) begin
                out_valid_d = 1'b1;
                out_reg_d   = dst_q;
                out_data_d  = '0;
                bus_err_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt_q       <= '0;
            op_q        <= '0;
            off_q       <= '0;
            dst_q       <= '0;
            wb_en_q     <= 1'b0;
            dm_we_q     <= 1'b0;
            dm_be_q     <= '0;
            dm_addr_q   <= '0;
            dm_wdata_q  <= '0;
            out_valid_q <= 1'b0;
            out_wb_en_q <= 1'b0;
            out_reg_q   <= '0;
            out_data_q  <= '0;
            misalign_q  <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            off_q       <= off_d;
            dst_q       <= dst_d;
            wb_en_q     <= wb_en_d;
            dm_we_q     <= dm_we_d;
            dm_be_q     <= dm_be_d;
            dm_addr_q   <= dm_addr_d;
            dm_wdata_q  <= dm_wdata_d;
            out_valid_q <= out_valid_d;
            out_wb_en_q <= out_wb_en_d;
            out_reg_q   <= out_reg_d;
            out_data_q  <= out_data_d;
            misalign_q  <= misalign_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign dm_we     = dm_we_q;
    assign dm_be     = dm_be_q;
    assign dm_addr   = dm_addr_q;
    assign dm_wdata  = dm_wdata_q;
    assign out_valid = out_valid_q;
    assign out_wb_en = out_wb_en_q;
    assign out_reg   = out_reg_q;
    assign out_data  = out_data_q;
    assign misalign  = misalign_q;
    assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_stage_hs.sv
// tb/tb_mem_stage_hs.sv - scoreboard bench for mem_stage_hs
module tb_mem_stage_hs;
    import mem_pkg::*;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        in_valid, in_wb_en, wb_valid, dm_ack;
    logic [3:0]  in_op;
    logic [31:0] in_addr, in_sdata, wb_data, dm_rdata;
    logic [4:0]  in_src_reg, in_dst_reg, wb_reg;
    logic        dm_req, dm_we, stall, out_valid, out_wb_en, misalign, bus_err;
    logic [3:0]  dm_be;
    logic [31:0] dm_addr, dm_wdata, out_data;
    logic [4:0]  out_reg;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        chk_data;
        logic        wb_en;
        logic        mis;
        logic        berr;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    logic        cap_we;
    logic [3:0]  cap_be;
    logic [31:0] cap_addr, cap_wdata;

    mem_stage_hs #(.DATA_W(32), .REG_AW(5), .TIMEOUT(8)) dut (
        .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_op(in_op), .in_addr(in_addr),
        .in_sdata(in_sdata), .in_src_reg(in_src_reg), .in_dst_reg(in_dst_reg),
        .in_wb_en(in_wb_en), .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_ack(dm_ack), .dm_rdata(dm_rdata), .stall(stall),
        .out_valid(out_valid), .out_wb_en(out_wb_en), .out_reg(out_reg),
        .out_data(out_data), .misalign(misalign), .bus_err(bus_err)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (!RESET) begin
                if (out_valid) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_out_valid", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("out_reg", 32'(out_reg), 32'(e.rd));
                        chk("out_wb_en", 32'(out_wb_en), 32'(e.wb_en));
                        chk("misalign", 32'(misalign), 32'(e.mis));
                        chk("bus_err", 32'(bus_err), 32'(e.berr));
                        if (e.chk_data) chk("out_data", out_data, e.data);
                    end
                end else begin
                    chk("idle_pulses", {30'd0, misalign, bus_err}, 32'd0);
                end
            end
        end
    end

    // Issues one op just after a rising edge and walks it through its BUSY phase.
    task automatic do_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd,
                         input logic [4:0] src, input logic [4:0] dst, input logic wben,
                         input int ack_after, input logic [31:0] rdata, input int exp_stall,
                         input exp_t e);
        int n;
        exp_q.push_back(e);
        in_valid = 1'b1; in_op = op; in_addr = addr; in_sdata = sd;
        in_src_reg = src; in_dst_reg = dst; in_wb_en = wben;
        @(posedge CLK); #1;
        n = 0;
        if (exp_stall == 0) chk("no_dm_req", 32'(dm_req), 32'd0);
        while (stall && n < 50) begin
            n++;
            if (n == 1) begin
                cap_we = dm_we; cap_be = dm_be; cap_addr = dm_addr; cap_wdata = dm_wdata;
            end
            if (n == ack_after) begin dm_ack = 1'b1; dm_rdata = rdata; end
            @(posedge CLK); #1;
            dm_ack = 1'b0;
        end
        in_valid = 1'b0;
        chk("stall_cycles", 32'(n), 32'(exp_stall));
        @(posedge CLK); #1;
    endtask

    initial begin
        RESET = 1'b1; in_valid = 0; in_op = 0; in_addr = 0; in_sdata = 0; in_src_reg = 0;
        in_dst_reg = 0; in_wb_en = 0; wb_valid = 0; wb_reg = 0; wb_data = 0; dm_ack = 0;
        dm_rdata = 0;
        repeat (2) @(posedge CLK);
        #1;
        chk("reset_outs", {25'd0, dm_req, dm_we, stall, out_valid, out_wb_en, misalign, bus_err}, 32'd0);
        chk("reset_dm_be", 32'(dm_be), 32'd0);
        chk("reset_dm_addr", dm_addr, 32'd0);
        RESET = 1'b0;
        @(posedge CLK); #1;

        // rd, data, chk_data, wb_en, mis, berr
        do_op(OP_NONE, 32'h1234, 0, 0, 5, 1, 0, 0, 0, '{5'd5, 32'h1234, 1'b1, 1'b1, 1'b0, 1'b0});
        do_op(OP_LB, 32'h101, 0, 0, 6, 1, 3, 32'h11F2_3344, 3, '{5'd6, 32'hFFFF_FFF2, 1'b1, 1'b1, 1'b0, 1'b0});
        chk("lb_dm_be", 32'(cap_be), 32'h4);
        chk("lb_dm_addr", cap_addr, 32'h100);
        chk("lb_dm_we", 32'(cap_we), 32'd0);
        do_op(OP_LBU, 32'h101, 0, 0, 6, 1, 3, 32'h11F2_3344, 3, '{5'd6, 32'h0000_00F2, 1'b1, 1'b1, 1'b0, 1'b0});
        do_op(OP_LH, 32'h102, 0, 0, 9, 1, 1, 32'h1122_8001, 1, '{5'd9, 32'hFFFF_8001, 1'b1, 1'b1, 1'b0, 1'b0});
        do_op(OP_LHU, 32'h100, 0, 0, 9, 1, 2, 32'h8001_1122, 2, '{5'd9, 32'h0000_8001, 1'b1, 1'b1, 1'b0, 1'b0});
        do_op(OP_LW, 32'h104, 0, 0, 3, 0, 1, 32'hDEAD_BEEF, 1, '{5'd3, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 1'b0});

        wb_valid = 1; wb_reg = 7; wb_data = 32'h0000_1234;
        do_op(OP_SH, 32'h202, 32'hAAAA_BEEF, 7, 2, 1, 2, 0, 2, '{5'd2, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0});
        chk("sh_dm_be", 32'(cap_be), 32'h3);
        chk("sh_dm_wdata", cap_wdata, 32'h1234_1234);
        chk("sh_dm_addr", cap_addr, 32'h200);
        chk("sh_dm_we", 32'(cap_we), 32'd1);

        wb_reg = 0; wb_data = 32'hFFFF_FFFF;
        do_op(OP_SB, 32'h103, 32'h0000_00A5, 0, 1, 0, 1, 0, 1, '{5'd1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0});
        chk("sb_dm_be", 32'(cap_be), 32'h1);
        chk("sb_dm_wdata", cap_wdata, 32'hA5A5_A5A5);
        wb_valid = 0;
        do_op(OP_SW, 32'h104, 32'hCAFE_F00D, 4, 1, 0, 1, 0, 1, '{5'd1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0});
        chk("sw_dm_be", 32'(cap_be), 32'hF);
        chk("sw_dm_wdata", cap_wdata, 32'hCAFE_F00D);

        do_op(OP_LW, 32'h103, 0, 0, 8, 1, 0, 0, 0, '{5'd8, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0});
        do_op(OP_SH, 32'h201, 32'h55, 0, 8, 0, 0, 0, 0, '{5'd8, 32'h0, 1'b0, 1'b0, 1'b1, 1'b0});
        do_op(OP_LW, 32'h100, 0, 0, 10, 1, 0, 0, 8, '{5'd10, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1});
        do_op(OP_LW, 32'h100, 0, 0, 11, 1, 8, 32'h0BAD_CAFE, 8, '{5'd11, 32'h0BAD_CAFE, 1'b1, 1'b1, 1'b0, 1'b0});

        // Reset in the second BUSY cycle abandons the access.
        in_valid = 1; in_op = OP_LW; in_addr = 32'h100; in_dst_reg = 12; in_wb_en = 1;
        @(posedge CLK); #1;
        in_valid = 0;
        chk("pre_reset_req", 32'(dm_req), 32'd1);
        @(posedge CLK); #2;
        RESET = 1'b1;
        #1;
        chk("reset_mid_req", 32'(dm_req), 32'd0);
        chk("reset_mid_outs", {26'd0, dm_we, stall, out_valid, out_wb_en, misalign, bus_err}, 32'd0);
        chk("reset_mid_addr", dm_addr, 32'd0);
        @(posedge CLK); #1;
        RESET = 1'b0;
        dm_ack = 1'b1; dm_rdata = 32'h1111_1111;
        @(posedge CLK); #1;
        dm_ack = 1'b0;
        chk("stray_ack_valid", 32'(out_valid), 32'd0);
        chk("stray_ack_stall", 32'(stall), 32'd0);
        @(posedge CLK); #1;

        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
